// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: bridges NPORT stb/ack bus masters onto one SDRAM controller request port and sequences its reset.
// Define SDRAM_ARB_RR_EN for round-robin arbitration; otherwise the lowest-index requesting port wins.
module sdram_port_arbiter #(
  parameter int NPORT = 2,
  parameter int DW = 16,
  parameter int AW = 21,
  parameter int ACK_DLY = 2,
  parameter int RST_DLY = 3,
  localparam int SW = DW / 8,
  localparam int GW = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sys_reset,
  output logic                ctrl_rst_n,
  input  logic [NPORT-1:0]    m_stb,
  input  logic [NPORT-1:0]    m_we,
  input  logic [NPORT*SW-1:0] m_sel,
  input  logic [NPORT*AW-1:0] m_adr,
  input  logic [NPORT*DW-1:0] m_dat_w,
  output logic [DW-1:0]       m_dat_r,
  output logic [NPORT-1:0]    m_ack,
  input  logic                ctrl_ready,
  output logic                ctrl_wr_req,
  output logic                ctrl_rd_req,
  input  logic                ctrl_wr_ack,
  input  logic                ctrl_rd_ack,
  output logic [AW-1:0]       ctrl_adr,
  output logic [DW-1:0]       ctrl_dat_w,
  input  logic [DW-1:0]       ctrl_dat_r,
  output logic [SW-1:0]       ctrl_be,
  output logic [SW-1:0]       dqm
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK, HOLD} state_t;
  state_t state, state_n;
  logic [GW-1:0] g, gsel;
  logic lat_we, abort, stb_g, grant, wr_done, rd_done, done;
  logic [2:0] dcnt;
  logic [1:0] sync;
  logic [3:0] rcnt;
  logic [AW-1:0] adr_a [NPORT];
  logic [DW-1:0] dat_a [NPORT];
  logic [SW-1:0] sel_a [NPORT];
  for (genvar i = 0; i < NPORT; i++) begin : g_port
    assign adr_a[i] = m_adr[i*AW +: AW];
    assign dat_a[i] = m_dat_w[i*DW +: DW];
    assign sel_a[i] = m_sel[i*SW +: SW];
  end
  // sys_reset is asynchronous to clk; the counter only starts once the synchronised copy is low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= 2'b11;
      rcnt <= '0;
    end else begin
      sync <= {sync[0], sys_reset};
      rcnt <= sync[1] ? 4'd0 : (rcnt == 4'(RST_DLY)) ? rcnt : rcnt + 4'd1;
    end
  end
  assign ctrl_rst_n = (rcnt == 4'(RST_DLY));
`ifdef SDRAM_ARB_RR_EN
  logic [GW-1:0] ptr;
  // lowest requester above the last grant wins; if none, wrap to the lowest requester overall
  always_comb begin
    gsel = '0;
    for (int i = NPORT - 1; i >= 0; i--) if (m_stb[i]) gsel = GW'(i);
    for (int i = NPORT - 1; i >= 0; i--) if (m_stb[i] && GW'(i) > ptr) gsel = GW'(i);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) ptr <= '0;
    else if (grant) ptr <= gsel;
  end
`else
  always_comb begin
    gsel = '0;
    for (int i = NPORT - 1; i >= 0; i--) if (m_stb[i]) gsel = GW'(i);
  end
`endif
  assign stb_g = m_stb[g];
  assign grant = (state == IDLE) && ctrl_ready && (|m_stb);
  assign wr_done = ctrl_wr_req && ctrl_wr_ack;
  assign rd_done = ctrl_rd_req && ctrl_rd_ack;
  assign done = wr_done || rd_done;
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (grant) state_n = REQ;
      REQ:      if (done) state_n = WAIT_ACK;
      WAIT_ACK: if (dcnt == 3'd0) state_n = (abort || !stb_g) ? IDLE : HOLD;
      HOLD:     if (!stb_g) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      g <= '0;
      lat_we <= 1'b0;
      abort <= 1'b0;
      dcnt <= '0;
      ctrl_adr <= '0;
      ctrl_dat_w <= '0;
      ctrl_be <= '0;
      dqm <= '1;
      m_dat_r <= '0;
      ctrl_wr_req <= 1'b0;
      ctrl_rd_req <= 1'b0;
      m_ack <= '0;
    end else begin
      if (grant) begin
        g <= gsel;
        lat_we <= m_we[gsel];
        ctrl_adr <= adr_a[gsel];
        ctrl_dat_w <= dat_a[gsel];
        ctrl_be <= sel_a[gsel];
        dqm <= m_we[gsel] ? ~sel_a[gsel] : '0;
        abort <= 1'b0;
      end else if ((state == REQ || state == WAIT_ACK) && !stb_g) begin
        abort <= 1'b1;
      end
      // requests rise one cycle after REQ entry and drop on the matching ack only
      ctrl_wr_req <= (state == REQ) && lat_we && !done;
      ctrl_rd_req <= (state == REQ) && !lat_we && !done;
      if (rd_done) m_dat_r <= ctrl_dat_r;
      dcnt <= done ? 3'(ACK_DLY) : (state == WAIT_ACK && dcnt != 3'd0) ? dcnt - 3'd1 : dcnt;
      m_ack <= (state_n == HOLD) ? (NPORT'(1) << g) : '0;
    end
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed and randomized transactions checked against a timing/arbitration model of the bridge.
module tb_sdram_port_arbiter;
  localparam int NPORT = 2, DW = 16, AW = 21, ACK_DLY = 2, RST_DLY = 3, SW = DW / 8;
  logic clk = 1'b0, rst_n, sys_reset, ctrl_rst_n, ctrl_ready;
  logic [NPORT-1:0] m_stb, m_we, m_ack;
  logic [NPORT*SW-1:0] m_sel;
  logic [NPORT*AW-1:0] m_adr;
  logic [NPORT*DW-1:0] m_dat_w;
  logic [DW-1:0] m_dat_r, ctrl_dat_w, ctrl_dat_r;
  logic ctrl_wr_req, ctrl_rd_req, ctrl_wr_ack, ctrl_rd_ack;
  logic [AW-1:0] ctrl_adr;
  logic [SW-1:0] ctrl_be, dqm;
  int checks = 0, errors = 0;
  int last_g, eg, n;
  logic [DW-1:0] exp_dat_r;

  sdram_port_arbiter #(.NPORT(NPORT), .DW(DW), .AW(AW), .ACK_DLY(ACK_DLY), .RST_DLY(RST_DLY)) dut (
    .clk(clk), .rst_n(rst_n), .sys_reset(sys_reset), .ctrl_rst_n(ctrl_rst_n),
    .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel), .m_adr(m_adr), .m_dat_w(m_dat_w),
    .m_dat_r(m_dat_r), .m_ack(m_ack), .ctrl_ready(ctrl_ready),
    .ctrl_wr_req(ctrl_wr_req), .ctrl_rd_req(ctrl_rd_req),
    .ctrl_wr_ack(ctrl_wr_ack), .ctrl_rd_ack(ctrl_rd_ack),
    .ctrl_adr(ctrl_adr), .ctrl_dat_w(ctrl_dat_w), .ctrl_dat_r(ctrl_dat_r),
    .ctrl_be(ctrl_be), .dqm(dqm)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one complete master transaction; the controller acks after lat wait cycles
  task automatic txn(input int p, input bit we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                     input logic [SW-1:0] sel, input logic [DW-1:0] rd, input int lat, input bit abrt);
    logic [SW-1:0] edqm;
    logic [63:0] eack;
    edqm = we ? ~sel : '0;
    eack = abrt ? 64'd0 : (64'd1 << p);
    m_stb[p] = 1'b1;
    m_we[p] = we;
    m_adr[p*AW +: AW] = adr;
    m_dat_w[p*DW +: DW] = dat;
    m_sel[p*SW +: SW] = sel;
    tick();
    last_g = p;
    chk("req_not_yet", {ctrl_wr_req, ctrl_rd_req}, 2'b00);
    tick();
    chk("req_type", {ctrl_wr_req, ctrl_rd_req}, {we, !we});
    chk("latched_adr", ctrl_adr, adr);
    chk("latched_dat_w", ctrl_dat_w, dat);
    chk("latched_be", ctrl_be, sel);
    chk("latched_dqm", dqm, edqm);
    m_adr[p*AW +: AW] = AW'($urandom);
    m_dat_w[p*DW +: DW] = DW'($urandom);
    m_sel[p*SW +: SW] = SW'($urandom);
    if (abrt) m_stb[p] = 1'b0;
    repeat (lat) begin
      if ($urandom_range(0, 1) == 1) begin
        ctrl_dat_r = DW'($urandom);
        if (we) ctrl_rd_ack = 1'b1;
        else ctrl_wr_ack = 1'b1;
      end
      tick();
      ctrl_wr_ack = 1'b0;
      ctrl_rd_ack = 1'b0;
      chk("req_held", {ctrl_wr_req, ctrl_rd_req}, {we, !we});
      chk("ack_early", m_ack, 0);
    end
    ctrl_dat_r = rd;
    if (we) ctrl_wr_ack = 1'b1;
    else ctrl_rd_ack = 1'b1;
    tick();
    ctrl_wr_ack = 1'b0;
    ctrl_rd_ack = 1'b0;
    ctrl_dat_r = DW'($urandom);
    if (!we) exp_dat_r = rd;
    chk("req_cleared", {ctrl_wr_req, ctrl_rd_req}, 2'b00);
    chk("dat_r_capture", m_dat_r, exp_dat_r);
    for (int i = 1; i <= ACK_DLY; i++) begin
      tick();
      chk("ack_delay", m_ack, 0);
      chk("stable_adr", ctrl_adr, adr);
      chk("stable_dqm", dqm, edqm);
    end
    tick();
    chk(abrt ? "abort_no_ack" : "ack_rise", m_ack, eack);
    if (!abrt) begin
      repeat ($urandom_range(0, 2)) begin
        tick();
        chk("ack_hold", m_ack, eack);
      end
      m_stb[p] = 1'b0;
      chk("ack_before_fall", m_ack, eack);
      tick();
      chk("ack_fall", m_ack, 0);
    end else begin
      tick();
      chk("abort_quiet", {ctrl_wr_req, ctrl_rd_req, m_ack}, 0);
    end
    chk("dat_r_hold", m_dat_r, exp_dat_r);
  endtask

  initial begin
    rst_n = 1'b0;
    sys_reset = 1'b1;
    ctrl_ready = 1'b0;
    m_stb = '0;
    m_we = '0;
    m_sel = '0;
    m_adr = '0;
    m_dat_w = '0;
    ctrl_wr_ack = 1'b0;
    ctrl_rd_ack = 1'b0;
    ctrl_dat_r = '0;
    exp_dat_r = '0;
    last_g = 0;
    repeat (2) tick();
    chk("rst_ctrl_rst_n", ctrl_rst_n, 0);
    chk("rst_reqs", {ctrl_wr_req, ctrl_rd_req}, 0);
    chk("rst_m_ack", m_ack, 0);
    chk("rst_dqm", dqm, 2'b11);
    chk("rst_be", ctrl_be, 0);
    chk("rst_dat_r", m_dat_r, 0);
    chk("rst_adr", ctrl_adr, 0);
    chk("rst_dat_w", ctrl_dat_w, 0);
    rst_n = 1'b1;
    m_stb[0] = 1'b1;
    repeat (4) begin
      tick();
      chk("no_req_not_ready", {ctrl_wr_req, ctrl_rd_req}, 0);
      chk("ctrl_rst_held", ctrl_rst_n, 0);
    end
    m_stb = '0;
    sys_reset = 1'b0;
    n = 0;
    while (!ctrl_rst_n && n < 20) begin
      tick();
      n++;
    end
    chk("ctrl_rst_release_edges", n, 2 + RST_DLY);
    ctrl_ready = 1'b1;
    tick();
    txn(0, 1'b1, 21'h12345, 16'hA55A, 2'b10, 16'h0000, 1, 1'b0);
    tick();
    txn(1, 1'b0, 21'h00777, 16'h0000, 2'b11, 16'h1234, 2, 1'b0);
    tick();
    txn(0, 1'b1, 21'h0ABCD, 16'hBEEF, 2'b01, 16'h0000, 3, 1'b1);
    // both masters keep requesting; each drops stb for one cycle after being acked
    m_we = 2'b11;
    m_sel = '1;
    m_adr[0 +: AW] = 21'h00555;
    m_adr[AW +: AW] = 21'h00AAA;
    m_stb = 2'b11;
    for (int k = 0; k < 6; k++) begin
`ifdef SDRAM_ARB_RR_EN
      eg = -1;
      for (int s = 1; s <= NPORT; s++)
        if (eg < 0 && m_stb[(last_g + s) % NPORT]) eg = (last_g + s) % NPORT;
`else
      eg = -1;
      for (int s = NPORT - 1; s >= 0; s--) if (m_stb[s]) eg = s;
`endif
      n = 0;
      while (!ctrl_wr_req && n < 10) begin
        tick();
        n++;
      end
      chk("cont_req_seen", ctrl_wr_req, 1);
      chk("cont_grant_adr", ctrl_adr, (eg == 1) ? 21'h00AAA : 21'h00555);
      ctrl_wr_ack = 1'b1;
      tick();
      ctrl_wr_ack = 1'b0;
      n = 0;
      while (m_ack == 0 && n < 10) begin
        tick();
        n++;
      end
      chk("cont_grant_ack", m_ack, 64'd1 << eg);
      last_g = eg;
      m_stb[eg] = 1'b0;
      tick();
      if (k < 5) m_stb[eg] = 1'b1;
    end
    m_stb = '0;
    tick();
    for (int k = 0; k < 12; k++) begin
      txn(int'($urandom_range(0, NPORT - 1)), 1'($urandom), AW'($urandom), DW'($urandom),
          SW'($urandom), DW'($urandom), int'($urandom_range(0, 3)), $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 1) tick();
    end
    m_stb[1] = 1'b1;
    m_we[1] = 1'b1;
    m_sel[SW +: SW] = 2'b01;
    tick();
    tick();
    chk("midrst_req", ctrl_wr_req, 1);
    ctrl_wr_ack = 1'b1;
    tick();
    ctrl_wr_ack = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("midrst_reqs", {ctrl_wr_req, ctrl_rd_req}, 0);
    chk("midrst_ack", m_ack, 0);
    chk("midrst_dqm", dqm, 2'b11);
    chk("midrst_be", ctrl_be, 0);
    chk("midrst_dat_r", m_dat_r, 0);
    chk("midrst_ctrl_rst_n", ctrl_rst_n, 0);
    rst_n = 1'b1;
    m_stb = '0;
    exp_dat_r = '0;
    last_g = 0;
    tick();
    txn(1, 1'b0, 21'h1FFFF, 16'h0000, 2'b11, 16'hC3C3, 0, 1'b0);
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Multi-port bridge between N bus masters (stb/we/sel/ack handshake) and the single request/acknowledge port of the SDRAM controller (`sdram_top`).
- Arbitrates the masters and latches address, write data and byte mask per transaction.
- Drives the controller's write/read requests and DQM lines, and returns a delayed, stb-qualified ack to the granted master.
- Also generates the controller's delayed reset.
- Sits between `topboard`-side memory clients (CPU, video, DMA) and the SDRAM controller in the board top level.

## Interface
- NPORT, 2, number of master ports (1..8)
- DW, 16, data width; byte lanes SW = DW/8
- AW, 21, word address width
- ACK_DLY, 2, cycles from controller ack to master ack (1..7)
- RST_DLY, 3, cycles controller reset is held after system reset release (1..15)

Ports:
- clk  in  1  controller clock (100 MHz domain)
- rst_n  in  1  block reset; synchronous, active-low
- sys_reset  in  1  core DRAM reset request, active-high, asynchronous to clk
- ctrl_rst_n  out  1  reset to SDRAM controller
- m_stb  in  NPORT  per-port transaction strobe
- m_we  in  NPORT  per-port write enable
- m_sel  in  NPORT*SW  per-port byte selects, port p at [p*SW +: SW]
- m_adr  in  NPORT*AW  per-port word address
- m_dat_w  in  NPORT*DW  per-port write data
- m_dat_r  out  DW  read data, shared by all ports
- m_ack  out  NPORT  per-port acknowledge
- ctrl_ready  in  1  controller init done
- ctrl_wr_req, ctrl_rd_req  out  1 each  controller requests
- ctrl_wr_ack, ctrl_rd_ack  in  1 each  controller one-cycle acks
- ctrl_adr  out  AW  latched address
- ctrl_dat_w  out  DW  latched write data
- ctrl_dat_r  in  DW  controller read data, valid with ctrl_rd_ack
- ctrl_be  out  SW  latched byte selects
- dqm  out  SW  DQM lines, 1 = byte masked

## Operation
- **Reset sequencer.**
  - sys_reset passes through a two-flop synchroniser.
  - While the synchronised sys_reset is high: ctrl_rst_n = 0 and the counter is cleared.
  - After release, the counter runs to RST_DLY, then ctrl_rst_n = 1.
  - rst_n low also forces ctrl_rst_n = 0.
- **FSM states:** IDLE, REQ, WAIT_ACK, HOLD.
- **IDLE.** If ctrl_ready and any m_stb, the arbiter picks port g and latches:
  - adr, dat_w, we, sel from port g;
  - ctrl_be = sel;
  - dqm = ~sel for a write, all-zero for a read.
  - Next state is REQ. No grant while ctrl_ready = 0.
- **REQ.**
  - ctrl_wr_req = we and ctrl_rd_req = ~we, held high until the matching ctrl ack.
  - On ctrl_rd_ack, ctrl_dat_r is captured into m_dat_r.
  - On ack: clear the request, load the delay counter with ACK_DLY, go to WAIT_ACK.
- **WAIT_ACK.** Counter decrements each cycle; at 0, go to HOLD.
- **HOLD.**
  - m_ack[g] = m_stb[g]; the ack is held while stb stays high.
  - When m_stb[g] = 0, go to IDLE.
- **Master abort.** If m_stb[g] drops during REQ or WAIT_ACK, the controller transaction still completes, but no m_ack is produced and the FSM returns to IDLE when it would have entered HOLD.
- **Stability.** Latched adr, dat_w, be and dqm are stable from the REQ entry cycle until return to IDLE. m_dat_r holds its last captured value otherwise.
- **Other ports.** Only m_ack[g] can be high; all other acks are 0.
- **Simultaneous events.** A ctrl ack for the opposite request type is ignored.

## Timing
- **Reset values (rst_n = 0 at a clk edge):**
  - FSM = IDLE, m_ack = 0, ctrl_wr_req = ctrl_rd_req = 0, ctrl_rst_n = 0;
  - dqm = all-ones, ctrl_be = 0, m_dat_r = 0, ctrl_adr = 0, ctrl_dat_w = 0, RR pointer = 0.
  - Reset mid-transaction abandons it immediately.
- **Request latency.** m_stb sampled high in IDLE at edge k gives ctrl_*_req high after edge k+1.
- **Ack latency.** ctrl ack sampled at edge j gives m_ack high after edge j+ACK_DLY+1.
- **Minimum spacing.** Back-to-back transactions are at least one IDLE cycle apart.
- **Controller reset release.** ctrl_rst_n rises 2+RST_DLY edges after sys_reset falls.

## Configuration
- **SDRAM_ARB_RR_EN defined:** round-robin arbitration.
  - Search starts at port (last_grant+1) mod NPORT.
  - The pointer updates on each grant.
- **Undefined:** fixed priority, lowest port index wins; the pointer logic is not built.

## Test plan
- **Reset release.** rst_n = 1, sys_reset 1→0, RST_DLY = 3 -> ctrl_rst_n rises exactly 5 edges later; with sys_reset = 1 and ctrl_ready = 0, no request is issued.
- **Single write.** Port 0 write, adr = 0x12345, dat = 0xA55A, sel = 2'b10 -> ctrl_wr_req one cycle later, dqm = 2'b01, ctrl_be = 2'b10; after ctrl_wr_ack, m_ack[0] rises 3 edges later (ACK_DLY = 2) and falls one cycle after m_stb drops.
- **Single read.** Port 1 read, ctrl_dat_r = 0x1234 with ctrl_rd_ack -> dqm = 2'b00, m_dat_r = 0x1234, m_ack[1] high, m_ack[0] = 0 throughout.
- **Contention.** Ports 0 and 1 hold stb continuously -> with SDRAM_ARB_RR_EN, grants alternate 0,1,0,1; without it, port 0 is served repeatedly until it drops stb.
- **Abort.** Port 0 drops stb while in REQ -> the controller request is held until ctrl_wr_ack, m_ack[0] never rises, FSM returns to IDLE.
- **Reset mid-transaction.** rst_n = 0 during WAIT_ACK -> next edge: all requests and acks are 0 and dqm is all-ones.
